// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared 7-segment bus.
// Grants the segment lines to one digit per slot in round-robin order, blanks
// all anodes at the start of every slot to prevent ghosting, and snapshots
// the digit/dp/lz inputs once per frame so values never tear mid-scan.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lz_sup,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(DIGIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_lz;

    // Segment pattern {a..g,dp} for digit idx of the given frame values,
    // including leading-zero suppression (digit 0 is never suppressed).
    function automatic logic [7:0] seg_pattern(
        input logic [4*NUM_DIGITS-1:0] d,
        input logic [NUM_DIGITS-1:0]   p,
        input logic                    lz,
        input logic [IDX_W-1:0]        idx
    );
        logic [3:0] v;
        logic [6:0] s;
        logic       all_zero;
        v        = d[4*idx +: 4];
        all_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (k >= 32'(idx) && d[4*k +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        case (v)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        if (lz && idx != '0 && all_zero) begin
            s = '0;
        end
        return {s, p[idx]};
    endfunction

    // Scan FSM: slot counter, digit rotation, per-frame snapshot and registered outputs.
    // seg is loaded on entry to BLANK so it is already stable when the anode turns on;
    // at frame start the pattern is taken from the raw inputs being snapshotted that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            an          <= '1;
            seg         <= '0;
            digit_idx   <= '0;
            frame_start <= 1'b0;
            cnt         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_lz     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    an        <= '1;
                    seg       <= '0;
                    digit_idx <= '0;
                    cnt       <= '0;
                    if (en) begin
                        state       <= BLANK;
                        snap_digits <= digits_in;
                        snap_dp     <= dp_in;
                        snap_lz     <= lz_sup;
                        frame_start <= 1'b1;
                        seg         <= seg_pattern(digits_in, dp_in, lz_sup, '0);
                    end
                end
                BLANK: begin
                    if (!en) begin
                        state     <= IDLE;
                        an        <= '1;
                        seg       <= '0;
                        cnt       <= '0;
                        digit_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                            state <= SHOW;
                            an    <= ~(NUM_DIGITS'(1) << digit_idx);
                        end
                    end
                end
                SHOW: begin
                    if (!en) begin
                        state     <= IDLE;
                        an        <= '1;
                        seg       <= '0;
                        cnt       <= '0;
                        digit_idx <= '0;
                    end else if (cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
                        state <= BLANK;
                        cnt   <= '0;
                        an    <= '1;
                        if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                            digit_idx   <= '0;
                            snap_digits <= digits_in;
                            snap_dp     <= dp_in;
                            snap_lz     <= lz_sup;
                            frame_start <= 1'b1;
                            seg         <= seg_pattern(digits_in, dp_in, lz_sup, '0);
                        end else begin
                            digit_idx <= digit_idx + 1'b1;
                            seg       <= seg_pattern(snap_digits, snap_dp, snap_lz,
                                                     digit_idx + 1'b1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    an    <= '1;
                    seg   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
